// File: rtl/mux8_scan_sequencer_if.sv
// Bundle of the word handshakes, the mux drive/observe lines and the status outputs.
// The master side belongs to the sequencer; the slave side is the surrounding environment.
interface mux8_scan_sequencer_if #(
  parameter int unsigned ERR_CNT_W = 8
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [7:0]           in_data;
  logic [7:0]           mux_data;
  logic [2:0]           mux_sel;
  logic                 mux_y;
  logic                 out_valid;
  logic                 out_ready;
  logic [7:0]           out_data;
  logic                 out_err;
  logic [ERR_CNT_W-1:0] err_count;
  logic                 busy;

  modport master (
    input  in_valid, in_data, mux_y, out_ready,
    output in_ready, mux_data, mux_sel, out_valid, out_data, out_err, err_count, busy
  );

  modport slave (
    output in_valid, in_data, mux_y, out_ready,
    input  in_ready, mux_data, mux_sel, out_valid, out_data, out_err, err_count, busy
  );
endinterface

// File: rtl/mux8_scan_sequencer.sv
// Drives an 8:1 mux with a word, walks the select lines, samples Y after a settle
// interval and returns the reassembled word with a mismatch flag and error count.
module mux8_scan_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned ERR_CNT_W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mux8_scan_sequencer_if.master  bus
);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  state_t               state_reg;
  logic [3:0]           cnt_reg;
  logic [7:0]           cap_reg;
  logic [7:0]           cap_next;
  logic [7:0]           mux_data_reg;
  logic [2:0]           mux_sel_reg;
  logic [7:0]           out_data_reg;
  logic                 out_err_reg;
  logic                 out_valid_reg;
  logic                 in_ready_reg;
  logic                 busy_reg;
  logic [ERR_CNT_W-1:0] err_count_reg;

  // Capture word with the bit for the current select replaced by Y, so the
  // final word can be compared in the same cycle the last bit is taken.
  for (genvar gi = 0; gi < 8; gi++) begin : g_cap
    assign cap_next[gi] = (mux_sel_reg == 3'(gi)) ? bus.mux_y : cap_reg[gi];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      cap_reg       <= '0;
      mux_data_reg  <= '0;
      mux_sel_reg   <= '0;
      out_data_reg  <= '0;
      out_err_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
      busy_reg      <= 1'b0;
      err_count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid && in_ready_reg) begin
            mux_data_reg <= bus.in_data;
            mux_sel_reg  <= 3'd0;
            cnt_reg      <= SETTLE_INIT;
            cap_reg      <= '0;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_reg == 4'd0) begin
            state_reg <= SAMPLE;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        SAMPLE: begin
          cap_reg <= cap_next;
          if (mux_sel_reg == 3'd7) begin
            out_data_reg  <= cap_next;
            out_err_reg   <= (cap_next != mux_data_reg);
            out_valid_reg <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= DONE;
          end else begin
            mux_sel_reg <= mux_sel_reg + 3'd1;
            cnt_reg     <= SETTLE_INIT;
            state_reg   <= SETTLE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
            if (out_err_reg && (err_count_reg != '1)) begin
              err_count_reg <= err_count_reg + ERR_CNT_W'(1);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.mux_data  = mux_data_reg;
  assign bus.mux_sel   = mux_sel_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_err   = out_err_reg;
  assign bus.err_count = err_count_reg;
  assign bus.busy      = busy_reg;
endmodule

// File: tb/tb_mux8_scan_sequencer.sv
// Directed bench: one sequencer with default settings around a mux model, plus a
// second instance with no settle cycles and a 2-bit error counter.
module tb_mux8_scan_sequencer;
  localparam int SET_A = 1;
  localparam int SET_B = 0;

  logic clk = 1'b0;
  logic rst_n_a = 1'b0;
  logic rst_n_b = 1'b0;
  logic stuck_a = 1'b0;
  logic stuck_b = 1'b1;
  int   checks_cnt = 0;
  int   errors_cnt = 0;

  always #5 clk = ~clk;

  mux8_scan_sequencer_if #(.ERR_CNT_W(8)) bus_a ();
  mux8_scan_sequencer_if #(.ERR_CNT_W(2)) bus_b ();

  // Mux models: a correct 8:1 selector, or Y stuck at 0.
  assign bus_a.mux_y = stuck_a ? 1'b0 : bus_a.mux_data[bus_a.mux_sel];
  assign bus_b.mux_y = stuck_b ? 1'b0 : bus_b.mux_data[bus_b.mux_sel];

  mux8_scan_sequencer #(.SETTLE_CYCLES(SET_A), .ERR_CNT_W(8)) dut_a (
    .clk   (clk),
    .rst_n (rst_n_a),
    .bus   (bus_a)
  );

  mux8_scan_sequencer #(.SETTLE_CYCLES(SET_B), .ERR_CNT_W(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n_b),
    .bus   (bus_b)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks_cnt++;
    if (act !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic start_a(input logic [7:0] word);
    @(posedge clk); #1;
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = word;
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0;
  endtask

  // Called #1 after the accepting edge; follows the select walk and the latency.
  task automatic wait_a(input string tag, input logic [7:0] exp_data, input logic exp_err);
    int lat = 0;
    while (bus_a.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if ((lat % (SET_A + 2)) == 1 && lat < 8 * (SET_A + 2))
        check({tag, "_sel"}, 32'(bus_a.mux_sel), 32'(lat / (SET_A + 2)));
    end
    check({tag, "_lat"}, 32'(lat), 32'(8 * (SET_A + 2)));
    check({tag, "_data"}, 32'(bus_a.out_data), 32'(exp_data));
    check({tag, "_err"}, 32'(bus_a.out_err), 32'(exp_err));
    check({tag, "_busy"}, 32'(bus_a.busy), 32'd0);
    $display("scan %s: word=%02h out_data=%02h out_err=%0b latency=%0d",
             tag, bus_a.mux_data, bus_a.out_data, bus_a.out_err, lat);
  endtask

  task automatic release_a(input string tag, input logic [7:0] exp_cnt);
    bus_a.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_a.out_ready = 1'b0;
    check({tag, "_ovld"}, 32'(bus_a.out_valid), 32'd0);
    check({tag, "_rdy"}, 32'(bus_a.in_ready), 32'd1);
    check({tag, "_cnt"}, 32'(bus_a.err_count), 32'(exp_cnt));
  endtask

  task automatic scan_b(input logic [7:0] word, input logic [1:0] exp_cnt);
    int lat = 0;
    @(posedge clk); #1;
    bus_b.in_valid = 1'b1;
    bus_b.in_data  = word;
    @(posedge clk); #1;
    bus_b.in_valid = 1'b0;
    while (bus_b.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("sat_lat", 32'(lat), 32'(8 * (SET_B + 2)));
    check("sat_data", 32'(bus_b.out_data), 32'h00);
    check("sat_err", 32'(bus_b.out_err), 32'd1);
    bus_b.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_b.out_ready = 1'b0;
    check("sat_cnt", 32'(bus_b.err_count), 32'(exp_cnt));
    $display("sat word=%02h out_data=%02h latency=%0d err_count=%0d",
             word, bus_b.out_data, lat, bus_b.err_count);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b0;

    // Reset, then idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rdy", 32'(bus_a.in_ready), 32'd1);
    check("rst_ovld", 32'(bus_a.out_valid), 32'd0);
    check("rst_busy", 32'(bus_a.busy), 32'd0);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    @(negedge clk);
    check("idle_rdy", 32'(bus_a.in_ready), 32'd1);
    check("idle_sel", 32'(bus_a.mux_sel), 32'd0);
    check("idle_mdata", 32'(bus_a.mux_data), 32'h00);
    check("idle_cnt", 32'(bus_a.err_count), 32'd0);
    check("idle_odata", 32'(bus_a.out_data), 32'h00);
    $display("reset released: in_ready=%0b out_valid=%0b", bus_a.in_ready, bus_a.out_valid);

    // Correct mux in the loop
    start_a(8'hCA);
    check("ok_acc_rdy", 32'(bus_a.in_ready), 32'd0);
    check("ok_acc_busy", 32'(bus_a.busy), 32'd1);
    check("ok_acc_mdata", 32'(bus_a.mux_data), 32'hCA);
    wait_a("ok", 8'hCA, 1'b0);
    release_a("ok", 8'd0);
    check("ok_hold_sel", 32'(bus_a.mux_sel), 32'd7);

    // out_ready while nothing is pending changes nothing
    bus_a.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus_a.out_ready = 1'b0;
    check("idle_ordy_cnt", 32'(bus_a.err_count), 32'd0);
    check("idle_ordy_rdy", 32'(bus_a.in_ready), 32'd1);

    // Stuck-at-0 mux
    stuck_a = 1'b1;
    start_a(8'hCA);
    wait_a("stuck", 8'h00, 1'b1);
    release_a("stuck", 8'd1);
    stuck_a = 1'b0;

    // Backpressure with a competing input word
    start_a(8'hCA);
    wait_a("bp", 8'hCA, 1'b0);
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 8'h55;
    repeat (10) @(posedge clk);
    #1;
    check("bp_ovld", 32'(bus_a.out_valid), 32'd1);
    check("bp_odata", 32'(bus_a.out_data), 32'hCA);
    check("bp_rdy", 32'(bus_a.in_ready), 32'd0);
    check("bp_mdata", 32'(bus_a.mux_data), 32'hCA);
    release_a("bp", 8'd1);
    check("bp_bubble_mdata", 32'(bus_a.mux_data), 32'hCA);
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0;
    check("bp_acc_mdata", 32'(bus_a.mux_data), 32'h55);
    check("bp_acc_busy", 32'(bus_a.busy), 32'd1);
    wait_a("bp55", 8'h55, 1'b0);
    release_a("bp55", 8'd1);

    // Reset in the middle of a scan
    start_a(8'hFF);
    n = 0;
    while (bus_a.mux_sel != 3'd4 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("mid_reach_sel4", 32'(bus_a.mux_sel), 32'd4);
    #2 rst_n_a = 1'b0;
    #1;
    check("mid_sel", 32'(bus_a.mux_sel), 32'd0);
    check("mid_mdata", 32'(bus_a.mux_data), 32'h00);
    check("mid_busy", 32'(bus_a.busy), 32'd0);
    check("mid_rdy", 32'(bus_a.in_ready), 32'd1);
    check("mid_cnt", 32'(bus_a.err_count), 32'd0);
    check("mid_odata", 32'(bus_a.out_data), 32'h00);
    $display("mid-scan reset: mux_sel=%0d err_count=%0d", bus_a.mux_sel, bus_a.err_count);
    @(negedge clk);
    rst_n_a = 1'b1;
    start_a(8'hFF);
    wait_a("fresh", 8'hFF, 1'b0);
    release_a("fresh", 8'd0);

    // Saturating 2-bit counter with a stuck mux and no settle cycles
    scan_b(8'h01, 2'd1);
    scan_b(8'h80, 2'd2);
    scan_b(8'hFF, 2'd3);
    scan_b(8'h3C, 2'd3);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end
endmodule
